// File: rtl/display_frame_controller.sv
// Back-buffer write sequencer: host pixel writes, whole-buffer fills and frame-synchronous buffer flips.
// mem_* are registered one cycle after acceptance; wr_ready is low during fill, pending commit and flip wait.
module display_frame_controller #(
    parameter int  ROWS    = 8,
    parameter int  COLUMNS = 32,
    parameter int  WIDTH   = 24,
    localparam int RW      = $clog2(ROWS),
    localparam int CW      = $clog2(COLUMNS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [RW-1:0]    wr_row,
    input  logic [CW-1:0]    wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fill_start,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             commit_req,
    input  logic             frame_end,
    output logic             commit_done,
    output logic             busy,
    output logic             mem_wen,
    output logic [RW-1:0]    mem_wrow,
    output logic [CW-1:0]    mem_wcol,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_flip
);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_FLIP} state_t;

    typedef struct packed {
        logic [RW-1:0]    row;
        logic [CW-1:0]    col;
        logic [WIDTH-1:0] dat;
    } pix_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

    state_t state_q, state_d;
    pix_t   pix_q, pix_d;
    logic   wen_q, wen_d;
    logic   flip_q, flip_d;
    logic   pending_q, pending_d;
    logic   toggled_q, toggled_d;
    logic   done_q, done_d;

    always_comb begin
        wr_ready = (state_q == IDLE) && !fill_start && !commit_req && !pending_q;
    end

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        wen_d     = 1'b0;
        flip_d    = flip_q;
        pending_d = pending_q;
        toggled_d = 1'b0;
        done_d    = toggled_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    wen_d   = 1'b1;
                    pix_d   = '{row: '0, col: '0, dat: fill_data};
                    if (commit_req) begin
                        pending_d = 1'b1;
                    end
                end else if (commit_req || pending_q) begin
                    state_d   = WAIT_FLIP;
                    pending_d = 1'b0;
                end else if (wr_valid) begin
                    wen_d = 1'b1;
                    pix_d = '{row: wr_row, col: wr_col, dat: wr_data};
                end
            end
            FILL: begin
                if (commit_req) begin
                    pending_d = 1'b1;
                end
                wen_d = 1'b1;
                // pix_q holds the address just written; step row-major, stop after the last cell
                if (pix_q.col == COL_LAST) begin
                    if (pix_q.row == ROW_LAST) begin
                        wen_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        pix_d.col = '0;
                        pix_d.row = pix_q.row + 1'b1;
                    end
                end else begin
                    pix_d.col = pix_q.col + 1'b1;
                end
            end
            WAIT_FLIP: begin
                if (frame_end) begin
                    flip_d    = ~flip_q;
                    toggled_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            wen_q     <= 1'b0;
            flip_q    <= 1'b0;
            pending_q <= 1'b0;
            toggled_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            wen_q     <= wen_d;
            flip_q    <= flip_d;
            pending_q <= pending_d;
            toggled_q <= toggled_d;
            done_q    <= done_d;
        end
    end

    assign mem_wen     = wen_q;
    assign mem_wrow    = pix_q.row;
    assign mem_wcol    = pix_q.col;
    assign mem_wdata   = pix_q.dat;
    assign mem_flip    = flip_q;
    assign commit_done = done_q;
    assign busy        = (state_q != IDLE) || pending_q;

endmodule

// File: tb/tb_display_frame_controller.sv
// Directed bench for display_frame_controller: vector table for write/commit cycles plus fill and reset sequences.
module tb_display_frame_controller;

    localparam int ROWS = 8;
    localparam int COLS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_row = '0;
    logic [4:0]  wr_col = '0;
    logic [23:0] wr_data = '0;
    logic        fill_start = 1'b0;
    logic [23:0] fill_data = '0;
    logic        commit_req = 1'b0;
    logic        frame_end = 1'b0;
    logic        commit_done;
    logic        busy;
    logic        mem_wen;
    logic [2:0]  mem_wrow;
    logic [4:0]  mem_wcol;
    logic [23:0] mem_wdata;
    logic        mem_flip;

    int checks = 0;
    int errors = 0;

    display_frame_controller #(.ROWS(ROWS), .COLUMNS(COLS), .WIDTH(24)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .fill_start(fill_start), .fill_data(fill_data),
        .commit_req(commit_req), .frame_end(frame_end),
        .commit_done(commit_done), .busy(busy),
        .mem_wen(mem_wen), .mem_wrow(mem_wrow), .mem_wcol(mem_wcol),
        .mem_wdata(mem_wdata), .mem_flip(mem_flip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  row;
        logic [4:0]  col;
        logic [23:0] dat;
        logic        cmt;
        logic        fe;
        logic        e_rdy;
        logic        e_wen;
        logic [2:0]  e_row;
        logic [4:0]  e_col;
        logic [23:0] e_dat;
        logic        e_flip;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(input logic vld, input logic [2:0] row, input logic [4:0] col,
                                input logic [23:0] dat, input logic cmt, input logic fe,
                                input logic e_rdy, input logic e_wen, input logic [2:0] e_row,
                                input logic [4:0] e_col, input logic [23:0] e_dat,
                                input logic e_flip, input logic e_done, input logic e_busy);
        vec_t v;
        v.vld = vld; v.row = row; v.col = col; v.dat = dat; v.cmt = cmt; v.fe = fe;
        v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_row = e_row; v.e_col = e_col; v.e_dat = e_dat;
        v.e_flip = e_flip; v.e_done = e_done; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; fill_start = 1'b0; commit_req = 1'b0; frame_end = 1'b0;
    endtask

    // Runs a complete fill; a stray fill_start and frame_end are injected mid-fill and must be ignored.
    task automatic run_fill(input logic [23:0] fd, input logic with_commit, input logic exp_flip);
        @(negedge clk);
        fill_start = 1'b1; fill_data = fd; commit_req = with_commit;
        #1;
        check("fill start wr_ready", wr_ready, 1'b0);
        for (int i = 0; i < ROWS * COLS; i++) begin
            @(posedge clk); #1;
            check($sformatf("fill beat %0d", i),
                  {mem_wen, mem_wrow, mem_wcol, mem_wdata, busy, wr_ready, mem_flip},
                  {1'b1, 3'(i / COLS), 5'(i % COLS), fd, 1'b1, 1'b0, exp_flip});
            @(negedge clk);
            commit_req = 1'b0;
            fill_start = (i == 50);
            fill_data  = (i == 50) ? 24'hFF0000 : fd;
            frame_end  = (i == 100);
        end
        @(posedge clk); #1;
        check("fill end wen", mem_wen, 1'b0);
        check("fill end flip", mem_flip, exp_flip);
    endtask

    initial begin
        vt[0]  = mk(0, 0, 0,  24'h0,      0, 0,  1, 0, 0, 0,  24'h0,      0, 0, 0);
        vt[1]  = mk(1, 3, 17, 24'h00FF00, 0, 0,  1, 1, 3, 17, 24'h00FF00, 0, 0, 0);
        vt[2]  = mk(1, 7, 31, 24'h123456, 0, 0,  1, 1, 7, 31, 24'h123456, 0, 0, 0);
        vt[3]  = mk(1, 0, 0,  24'hABCDEF, 0, 0,  1, 1, 0, 0,  24'hABCDEF, 0, 0, 0);
        vt[4]  = mk(0, 0, 0,  24'h0,      0, 0,  1, 0, 0, 0,  24'h0,      0, 0, 0);
        vt[5]  = mk(1, 1, 1,  24'h111111, 1, 1,  0, 0, 0, 0,  24'h0,      0, 0, 1);
        vt[6]  = mk(1, 1, 1,  24'h111111, 0, 0,  0, 0, 0, 0,  24'h0,      0, 0, 1);
        vt[7]  = mk(1, 1, 1,  24'h111111, 0, 1,  0, 0, 0, 0,  24'h0,      1, 0, 0);
        vt[8]  = mk(1, 1, 1,  24'h111111, 0, 0,  1, 1, 1, 1,  24'h111111, 1, 1, 0);
        vt[9]  = mk(0, 0, 0,  24'h0,      0, 0,  1, 0, 0, 0,  24'h0,      1, 0, 0);
        vt[10] = mk(0, 0, 0,  24'h0,      1, 0,  0, 0, 0, 0,  24'h0,      1, 0, 1);
        vt[11] = mk(0, 0, 0,  24'h0,      0, 1,  0, 0, 0, 0,  24'h0,      0, 0, 0);
        vt[12] = mk(0, 0, 0,  24'h0,      0, 0,  1, 0, 0, 0,  24'h0,      0, 1, 0);

        // reset state
        #3;
        check("reset outputs", {mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip, commit_done, busy}, 64'h0);
        @(negedge clk); rst = 1'b1;

        // a long idle gap between commit and frame_end, then the vector table
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0;
        repeat (49) @(negedge clk);
        frame_end = 1'b1;
        @(posedge clk); #1;
        check("late commit flip", mem_flip, 1'b1);
        @(negedge clk); frame_end = 1'b0;
        @(posedge clk); #1;
        check("late commit done", commit_done, 1'b1);
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0; frame_end = 1'b1;
        @(negedge clk); frame_end = 1'b0;
        #1;
        check("second commit flip", mem_flip, 1'b0);

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            wr_valid = vt[k].vld; wr_row = vt[k].row; wr_col = vt[k].col; wr_data = vt[k].dat;
            commit_req = vt[k].cmt; frame_end = vt[k].fe;
            #1;
            check($sformatf("v%0d wr_ready", k), wr_ready, vt[k].e_rdy);
            @(posedge clk); #1;
            check($sformatf("v%0d wen", k), mem_wen, vt[k].e_wen);
            check($sformatf("v%0d flip", k), mem_flip, vt[k].e_flip);
            check($sformatf("v%0d done", k), commit_done, vt[k].e_done);
            check($sformatf("v%0d busy", k), busy, vt[k].e_busy);
            if (vt[k].e_wen) begin
                check($sformatf("v%0d addr/data", k), {mem_wrow, mem_wcol, mem_wdata},
                      {vt[k].e_row, vt[k].e_col, vt[k].e_dat});
            end
        end
        @(negedge clk); idle_inputs();

        // plain fill
        run_fill(24'h0000FF, 1'b0, 1'b0);
        check("after fill busy", busy, 1'b0);
        check("after fill wr_ready", wr_ready, 1'b1);

        // fill with commit in the same cycle: fill runs fully, then flip waits for a fresh frame_end
        run_fill(24'h00FF00, 1'b1, 1'b0);
        check("pending busy", busy, 1'b1);
        @(posedge clk); #1;
        check("wait flip busy", busy, 1'b1);
        check("wait flip no flip", mem_flip, 1'b0);
        @(negedge clk); frame_end = 1'b1;
        @(posedge clk); #1;
        check("fill commit flip", mem_flip, 1'b1);
        @(negedge clk); frame_end = 1'b0;
        @(posedge clk); #1;
        check("fill commit done", commit_done, 1'b1);

        // asynchronous reset right after a write lands
        @(negedge clk);
        wr_valid = 1'b1; wr_row = 3'd5; wr_col = 5'd9; wr_data = 24'hAAAAAA;
        @(posedge clk); #1;
        check("pre-reset write", {mem_wen, mem_wrow, mem_wcol, mem_wdata}, {1'b1, 3'd5, 5'd9, 24'hAAAAAA});
        #1 rst = 1'b0;
        #1;
        check("async reset outputs", {mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip, commit_done, busy}, 64'h0);
        idle_inputs();
        @(negedge clk); rst = 1'b1;

        // reset mid-fill aborts it
        @(negedge clk); fill_start = 1'b1; fill_data = 24'h777777;
        @(negedge clk); fill_start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid-fill wen", mem_wen, 1'b1);
        rst = 1'b0;
        #1;
        check("fill reset wen", {mem_wen, busy}, 2'b00);
        @(negedge clk); rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("fill aborted", {mem_wen, busy}, 2'b00);
        end

        // reset mid-WAIT_FLIP: no flip afterwards
        @(negedge clk); commit_req = 1'b1;
        @(negedge clk); commit_req = 1'b0;
        #1;
        check("wait flip entered", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); frame_end = 1'b1;
        @(negedge clk); frame_end = 1'b0;
        @(posedge clk); #1;
        check("flip aborted", {mem_flip, commit_done, busy}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_frame_controller.md
Name: display_frame_controller

Overview:
- Sequences the write side of the double-buffered display memory for the LED-matrix panel.
- Accepts single-pixel writes and whole-buffer fills into the back buffer.
- On commit, waits for the display driver's end-of-frame and toggles the buffer flip, so buffer swaps are tear-free.
- Sits between host logic (UART/GPS renderer) and display_memory's wen/wrow/wcol/wdata/flip inputs.

Parameters:
- rows, 8, panel rows per scan half; address width clog2(rows).
- columns, 32, panel columns; address width clog2(columns).
- width, 24, pixel data width (8b R, 8b G, 8b B).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host pixel write request.
- wr_ready  out  1  controller accepts a write this cycle.
- wr_row  in  clog2(rows)  pixel row.
- wr_col  in  clog2(columns)  pixel column.
- wr_data  in  width  pixel value.
- fill_start  in  1  one-cycle pulse: write fill_data to every back-buffer location.
- fill_data  in  width  fill colour, sampled on fill_start.
- commit_req  in  1  one-cycle pulse: swap buffers at next frame end.
- frame_end  in  1  one-cycle pulse from display_driver after the last row/column/cycle of a frame.
- commit_done  out  1  one-cycle pulse on the cycle after mem_flip toggles.
- busy  out  1  high while in FILL or WAIT_FLIP, or while a commit is pending.
- mem_wen  out  1  display_memory write enable.
- mem_wrow  out  clog2(rows)  display_memory write row.
- mem_wcol  out  clog2(columns)  display_memory write column.
- mem_wdata  out  width  display_memory write data.
- mem_flip  out  1  display_memory buffer select.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_flip=0; mem_wen=0; mem_wrow=0; mem_wcol=0; mem_wdata=0.
  - commit_done=0; commit pending flag=0; busy=0.
  - A reset mid-FILL or mid-WAIT_FLIP aborts the operation; no flip occurs.
- All mem_* outputs are registered.
- States: IDLE, FILL, WAIT_FLIP.
- IDLE:
  - wr_ready = !fill_start && !commit_req && !pending (combinational).
  - A write is accepted when wr_valid && wr_ready. On the next cycle mem_wen=1 with the captured row/col/data. Latency is 1 cycle; throughput is 1 write/cycle.
  - When no write is accepted, mem_wen=0 on the next cycle.
- Priority in IDLE: fill_start > commit_req (or pending) > host write.
  - fill_start → FILL; fill_data is latched. If commit_req arrives in the same cycle, it sets pending.
  - commit_req or pending (without fill_start) → WAIT_FLIP; pending is cleared.
- FILL:
  - mem_wen=1 for exactly rows*columns consecutive cycles, starting the cycle after fill_start.
  - Address order is row-major: (0,0), (0,1) … (0,columns-1), (1,0) … (rows-1,columns-1). mem_wdata = latched fill_data.
  - After the last address: mem_wen=0 and state → IDLE.
  - commit_req during FILL sets pending; fill_start during FILL is ignored. wr_ready=0.
- WAIT_FLIP:
  - wr_ready=0; mem_wen=0.
  - On frame_end: mem_flip toggles on the next edge; commit_done pulses one cycle later; state → IDLE.
  - A frame_end in the same cycle as the transition into WAIT_FLIP is not counted.
  - commit_req and fill_start in WAIT_FLIP are ignored.
- frame_end in IDLE or FILL has no effect.
- Address counters wrap exactly at rows-1/columns-1; non-power-of-two sizes must not emit out-of-range addresses.
- Host writes with out-of-range wr_row/wr_col pass through unchanged; range checking is the requester's responsibility.

Test Plan:
- Reset, then write (row 3, col 17, 0x00FF00) with wr_valid=1 → next cycle mem_wen=1, mem_wrow=3, mem_wcol=17, mem_wdata=0x00FF00. Mid-write rst=0 → all outputs 0 immediately.
- fill_start with fill_data=0x0000FF → 256 consecutive mem_wen cycles covering (0,0)..(7,31) row-major, all data 0x0000FF. wr_ready=0 and busy=1 throughout, then back to IDLE.
- commit_req in IDLE, frame_end 50 cycles later → mem_flip 0→1 one cycle after frame_end; commit_done pulses the following cycle. A second commit plus frame_end → mem_flip=0.
- fill_start and commit_req in the same cycle → full 256-cycle fill, then WAIT_FLIP. frame_end arriving during the fill is ignored; the next frame_end flips.
- wr_valid held high with commit_req pulsed → wr_ready=0 that cycle and stays 0 until commit_done; the held write is then accepted in the first IDLE cycle.
- frame_end in the same cycle commit_req is accepted → no flip. The next frame_end flips.
